// File: rtl/spi_controller.sv
// SPI initiator, mode 0, MSB first, active-low chip select.
// One chip-select window carries an opcode byte, a run of operand bytes
// pulled from a valid/ready stream, then a run of read-back bytes.
module spi_controller #(
    parameter int CLOCK_DIVIDER = 2,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                   clock_in,
    input  logic                   reset_n_in,
    input  logic                   start_in,
    input  logic [7:0]             opcode_in,
    input  logic [COUNT_WIDTH-1:0] wr_byte_count_in,
    input  logic [COUNT_WIDTH-1:0] rd_byte_count_in,
    input  logic [7:0]             wr_data_in,
    input  logic                   wr_data_valid_in,
    output logic                   wr_data_ready_out,
    output logic [7:0]             rd_data_out,
    output logic                   rd_data_valid_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   spi_select_out,
    output logic                   spi_clock_out,
    output logic                   spi_data_out,
    input  logic                   spi_data_in
);

    localparam int DIV_W = (CLOCK_DIVIDER > 1) ? $clog2(CLOCK_DIVIDER) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDER - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        LOAD,
        HOLD,
        GAP
    } state_t;

    state_t                 state_reg, state_next;
    logic [DIV_W-1:0]       div_cnt_reg, div_cnt_next;
    logic [2:0]             bit_cnt_reg, bit_cnt_next;
    logic [COUNT_WIDTH-1:0] wr_left_reg, wr_left_next;
    logic [COUNT_WIDTH-1:0] rd_left_reg, rd_left_next;
    logic [7:0]             tx_shift_reg, tx_shift_next;
    logic [7:0]             rx_shift_reg, rx_shift_next;
    logic                   is_read_reg, is_read_next;
    logic                   sclk_reg, sclk_next;
    logic                   cs_reg, cs_next;
    logic                   done_reg, done_next;
    logic [7:0]             rd_data_reg, rd_data_next;
    logic                   rd_valid_reg, rd_valid_next;

    logic [7:0]             tx_shl;
    logic [7:0]             rx_shl;
    logic                   div_last;

    // Bit-wise shift networks: transmit moves toward the MSB and drops in a
    // zero, receive moves toward the MSB and drops in the sampled MISO bit.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : gen_shift
            if (gi == 0) begin : gen_lsb
                assign tx_shl[gi] = 1'b0;
                assign rx_shl[gi] = spi_data_in;
            end else begin : gen_upper
                assign tx_shl[gi] = tx_shift_reg[gi-1];
                assign rx_shl[gi] = rx_shift_reg[gi-1];
            end
        end
    endgenerate

    assign div_last = (div_cnt_reg == DIV_LAST);

    // State and datapath registers; reset drops the bus to idle immediately.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            bit_cnt_reg  <= '0;
            wr_left_reg  <= '0;
            rd_left_reg  <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            is_read_reg  <= 1'b0;
            sclk_reg     <= 1'b0;
            cs_reg       <= 1'b1;
            done_reg     <= 1'b0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            div_cnt_reg  <= div_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            wr_left_reg  <= wr_left_next;
            rd_left_reg  <= rd_left_next;
            tx_shift_reg <= tx_shift_next;
            rx_shift_reg <= rx_shift_next;
            is_read_reg  <= is_read_next;
            sclk_reg     <= sclk_next;
            cs_reg       <= cs_next;
            done_reg     <= done_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    // Next-state logic: sequences the byte stream and paces SCLK phases.
    always_comb begin
        state_next    = state_reg;
        div_cnt_next  = div_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        wr_left_next  = wr_left_reg;
        rd_left_next  = rd_left_reg;
        tx_shift_next = tx_shift_reg;
        rx_shift_next = rx_shift_reg;
        is_read_next  = is_read_reg;
        sclk_next     = sclk_reg;
        cs_next       = cs_reg;
        done_next     = 1'b0;
        rd_data_next  = rd_data_reg;
        rd_valid_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_in) begin
                    state_next    = SETUP;
                    cs_next       = 1'b0;
                    sclk_next     = 1'b0;
                    div_cnt_next  = '0;
                    bit_cnt_next  = '0;
                    tx_shift_next = opcode_in;
                    wr_left_next  = wr_byte_count_in;
                    rd_left_next  = rd_byte_count_in;
                    is_read_next  = 1'b0;
                end
            end

            SETUP: begin
                if (div_last) begin
                    div_cnt_next = '0;
                    state_next   = SHIFT;
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_ONE;
                end
            end

            SHIFT: begin
                if (!div_last) begin
                    div_cnt_next = div_cnt_reg + DIV_ONE;
                end else begin
                    div_cnt_next = '0;
                    if (!sclk_reg) begin
                        // Rising edge: the peripheral's bit is stable here.
                        sclk_next     = 1'b1;
                        rx_shift_next = rx_shl;
                    end else begin
                        // Falling edge: advance to next bit or next byte.
                        sclk_next = 1'b0;
                        if (bit_cnt_reg == 3'd7) begin
                            bit_cnt_next  = '0;
                            tx_shift_next = '0;
                            if (is_read_reg) begin
                                rd_data_next  = rx_shift_reg;
                                rd_valid_next = 1'b1;
                            end
                            if (wr_left_reg != '0) begin
                                wr_left_next = wr_left_reg - CNT_ONE;
                                state_next   = LOAD;
                            end else if (rd_left_reg != '0) begin
                                rd_left_next = rd_left_reg - CNT_ONE;
                                is_read_next = 1'b1;
                            end else begin
                                state_next = HOLD;
                            end
                        end else begin
                            bit_cnt_next  = bit_cnt_reg + 3'd1;
                            tx_shift_next = tx_shl;
                        end
                    end
                end
            end

            LOAD: begin
                if (wr_data_valid_in) begin
                    tx_shift_next = wr_data_in;
                    state_next    = SHIFT;
                    div_cnt_next  = '0;
                    is_read_next  = 1'b0;
                end
            end

            HOLD: begin
                if (div_last) begin
                    div_cnt_next = '0;
                    cs_next      = 1'b1;
                    done_next    = 1'b1;
                    state_next   = GAP;
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_ONE;
                end
            end

            GAP: begin
                if (div_last) begin
                    div_cnt_next = '0;
                    state_next   = IDLE;
                end else begin
                    div_cnt_next = div_cnt_reg + DIV_ONE;
                end
            end

            default: begin
                state_next = IDLE;
                cs_next    = 1'b1;
                sclk_next  = 1'b0;
            end
        endcase
    end

    assign wr_data_ready_out = (state_reg == LOAD);
    assign busy_out          = (state_reg != IDLE);
    assign done_out          = done_reg;
    assign rd_data_out       = rd_data_reg;
    assign rd_data_valid_out = rd_valid_reg;
    assign spi_select_out    = cs_reg;
    assign spi_clock_out     = sclk_reg;
    assign spi_data_out      = tx_shift_reg[7];

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: two instances (divider 2 and divider 1) share
// the request inputs; a per-instance peripheral model answers on MISO.
module tb_spi_controller;

    logic        clk;
    logic        rst_n;
    logic        start_a;
    logic        start_b;
    logic [7:0]  opcode;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic [7:0]  wr_data;
    logic        wr_valid;

    logic        ready    [2];
    logic [7:0]  rd_data  [2];
    logic        rd_valid [2];
    logic        busy     [2];
    logic        done     [2];
    logic        cs       [2];
    logic        sclk     [2];
    logic        mosi     [2];

    logic [63:0] shifter   [2] = '{64'd0, 64'd0};
    logic [63:0] miso_pat  [2] = '{64'd0, 64'd0};
    logic [63:0] mosi_acc  [2] = '{64'd0, 64'd0};
    int          cs_low_cnt[2] = '{0, 0};
    int          rise_cnt  [2] = '{0, 0};
    int          hi_cnt    [2] = '{0, 0};
    int          done_cnt  [2] = '{0, 0};
    int          rdv_cnt   [2] = '{0, 0};
    int          hs_cnt    [2] = '{0, 0};
    logic        sclk_prev [2] = '{1'b0, 1'b0};
    logic        cs_prev   [2] = '{1'b1, 1'b1};

    int checks = 0;
    int errors = 0;

    spi_controller #(.CLOCK_DIVIDER(2), .COUNT_WIDTH(16)) dut_a (
        .clock_in(clk), .reset_n_in(rst_n), .start_in(start_a),
        .opcode_in(opcode), .wr_byte_count_in(wr_cnt), .rd_byte_count_in(rd_cnt),
        .wr_data_in(wr_data), .wr_data_valid_in(wr_valid),
        .wr_data_ready_out(ready[0]), .rd_data_out(rd_data[0]),
        .rd_data_valid_out(rd_valid[0]), .busy_out(busy[0]), .done_out(done[0]),
        .spi_select_out(cs[0]), .spi_clock_out(sclk[0]), .spi_data_out(mosi[0]),
        .spi_data_in(shifter[0][63])
    );

    spi_controller #(.CLOCK_DIVIDER(1), .COUNT_WIDTH(16)) dut_b (
        .clock_in(clk), .reset_n_in(rst_n), .start_in(start_b),
        .opcode_in(opcode), .wr_byte_count_in(wr_cnt), .rd_byte_count_in(rd_cnt),
        .wr_data_in(wr_data), .wr_data_valid_in(wr_valid),
        .wr_data_ready_out(ready[1]), .rd_data_out(rd_data[1]),
        .rd_data_valid_out(rd_valid[1]), .busy_out(busy[1]), .done_out(done[1]),
        .spi_select_out(cs[1]), .spi_clock_out(sclk[1]), .spi_data_out(mosi[1]),
        .spi_data_in(shifter[1][63])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor and peripheral model, sampled on the inactive clock edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!cs[i]) cs_low_cnt[i] <= cs_low_cnt[i] + 1;
            if (sclk[i]) hi_cnt[i] <= hi_cnt[i] + 1;
            if (sclk[i] && !sclk_prev[i]) begin
                rise_cnt[i] <= rise_cnt[i] + 1;
                mosi_acc[i] <= {mosi_acc[i][62:0], mosi[i]};
            end
            if (cs_prev[i] && !cs[i]) shifter[i] <= miso_pat[i];
            else if (!sclk[i] && sclk_prev[i]) shifter[i] <= shifter[i] << 1;
            if (done[i]) done_cnt[i] <= done_cnt[i] + 1;
            if (rd_valid[i]) rdv_cnt[i] <= rdv_cnt[i] + 1;
            if (ready[i] && wr_valid) hs_cnt[i] <= hs_cnt[i] + 1;
            sclk_prev[i] <= sclk[i];
            cs_prev[i]   <= cs[i];
        end
    end

    typedef struct {
        int          sel;
        logic [7:0]  op;
        int          wr;
        int          rd;
        logic [23:0] wdata;
        int          stall;
        logic [15:0] miso;
        int          exp_cs;
        int          exp_rises;
        logic [63:0] exp_mosi;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input int s);
        chk("rst_cs", 64'(cs[s]), 64'd1);
        chk("rst_sclk", 64'(sclk[s]), 64'd0);
        chk("rst_mosi", 64'(mosi[s]), 64'd0);
        chk("rst_busy", 64'(busy[s]), 64'd0);
        chk("rst_done", 64'(done[s]), 64'd0);
        chk("rst_ready", 64'(ready[s]), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid[s]), 64'd0);
        chk("rst_rd_data", 64'(rd_data[s]), 64'd0);
    endtask

    task automatic pulse_start(input int s);
        if (s == 1) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_done(input int s);
        int n = 0;
        while (!done[s] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 64'(done[s]), 64'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int s = v.sel;
        int dv = (v.sel == 1) ? 1 : 2;
        int nbits = 8 * (1 + v.wr + v.rd);
        logic [63:0] mask = (64'd1 << nbits) - 64'd1;
        int cs0, rise0, hi0, done0, rdv0, hs0, lat, n;

        @(posedge clk); #1;
        cs0 = cs_low_cnt[s]; rise0 = rise_cnt[s]; hi0 = hi_cnt[s];
        done0 = done_cnt[s]; rdv0 = rdv_cnt[s]; hs0 = hs_cnt[s];
        miso_pat[s] = 64'(v.miso) << (64 - nbits);
        opcode = v.op;
        wr_cnt = 16'(v.wr);
        rd_cnt = 16'(v.rd);
        pulse_start(s);

        for (int j = 0; j < v.wr; j++) begin
            n = 0;
            while (!ready[s] && n < 500) begin
                @(posedge clk); #1;
                n++;
            end
            chk("ready_wait", 64'(ready[s]), 64'd1);
            if (j == v.wr - 1) begin
                repeat (v.stall) @(posedge clk);
                if (v.stall > 0) #1;
            end
            wr_data  = v.wdata[8*(v.wr-1-j) +: 8];
            wr_valid = 1'b1;
            @(posedge clk); #1;
            wr_valid = 1'b0;
        end

        wait_done(s);
        lat = 0;
        while (busy[s] && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        @(negedge clk); #1;

        chk("cs_low_cycles", 64'(cs_low_cnt[s] - cs0), 64'(v.exp_cs));
        chk("sclk_rises", 64'(rise_cnt[s] - rise0), 64'(v.exp_rises));
        chk("sclk_high_cycles", 64'(hi_cnt[s] - hi0), 64'(v.exp_rises * dv));
        chk("mosi_bits", mosi_acc[s] & mask, v.exp_mosi);
        chk("rd_pulses", 64'(rdv_cnt[s] - rdv0), 64'(v.rd));
        chk("handshakes", 64'(hs_cnt[s] - hs0), 64'(v.wr));
        chk("done_pulses", 64'(done_cnt[s] - done0), 64'd1);
        chk("busy_fall_latency", 64'(lat), 64'(dv));
        if (v.rd > 0) chk("rd_data", 64'(rd_data[s]), 64'(v.exp_rd));
        $display("txn %0d inst=%0d op=%02h wr=%0d rd=%0d cs_low=%0d rises=%0d rd_data=%02h",
                 idx, s, v.op, v.wr, v.rd, cs_low_cnt[s] - cs0, rise_cnt[s] - rise0, rd_data[s]);
    endtask

    initial begin
        int cs0, done0, hs0, rise0, n;

        //          sel op     wr rd wdata       stall miso      cs   rises mosi            rd
        vecs[0] = '{0, 8'hDB, 0, 0, 24'h000000, 0,  16'h0000, 36,  8,  64'hDB,         8'h00};
        vecs[1] = '{0, 8'hDB, 0, 1, 24'h000000, 0,  16'h0081, 68,  16, 64'hDB00,       8'h81};
        vecs[2] = '{0, 8'h12, 2, 0, 24'h00A53C, 10, 16'h0000, 112, 24, 64'h12A53C,     8'h00};
        vecs[3] = '{0, 8'h9C, 1, 2, 24'h000077, 0,  16'h5AC3, 133, 32, 64'h9C770000,   8'hC3};
        vecs[4] = '{1, 8'hA1, 1, 1, 24'h00003C, 0,  16'h00E7, 51,  24, 64'hA13C00,     8'hE7};

        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
        opcode = 8'h00; wr_cnt = 16'd0; rd_cnt = 16'd0;
        wr_data = 8'h00; wr_valid = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_state(0);
        check_reset_state(1);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Start requests during a transfer and during the CS-high gap are dropped.
        @(posedge clk); #1;
        cs0 = cs_low_cnt[0]; done0 = done_cnt[0]; hs0 = hs_cnt[0];
        opcode = 8'hDB; wr_cnt = 16'd0; rd_cnt = 16'd0;
        pulse_start(0);
        repeat (10) @(posedge clk);
        #1;
        opcode = 8'h55; wr_cnt = 16'd3;
        pulse_start(0);
        wait_done(0);
        @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        chk("ignored_done_pulses", 64'(done_cnt[0] - done0), 64'd1);
        chk("ignored_mosi", mosi_acc[0] & 64'hFF, 64'hDB);
        chk("ignored_handshakes", 64'(hs_cnt[0] - hs0), 64'd0);
        chk("ignored_cs_low", 64'(cs_low_cnt[0] - cs0), 64'd36);
        chk("ignored_busy_idle", 64'(busy[0]), 64'd0);
        $display("txn ignored-start inst=0 op=%02h done_pulses=%0d", opcode, done_cnt[0] - done0);

        // Reset in the middle of a write byte, then a clean transaction.
        opcode = 8'h12; wr_cnt = 16'd1; rd_cnt = 16'd0;
        rise0 = rise_cnt[0];
        pulse_start(0);
        n = 0;
        while (!ready[0] && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reset_seq_ready", 64'(ready[0]), 64'd1);
        wr_data = 8'hA5; wr_valid = 1'b1;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        n = 0;
        while (rise_cnt[0] < rise0 + 11 && n < 500) begin
            @(negedge clk); #1;
            n++;
        end
        chk("reset_seq_reached_bit3", 64'(rise_cnt[0] - rise0), 64'd11);
        rst_n = 1'b0;
        #1;
        check_reset_state(0);
        $display("txn reset-mid-write inst=0 cs=%0b sclk=%0b busy=%0b", cs[0], sclk[0], busy[0]);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run_vec(5, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- SPI initiator that drives the FPGA's own SPI peripheral protocol from the opposite end.
- Per transaction: one opcode byte, then N operand bytes written, then M bytes read back, all in a single chip-select window.
- Used for the on-chip loopback self-test and for the bench-side driver in the top-level and camera simulations.
- Mode 0, MSB first, chip select active low.

Parameters:
CLOCK_DIVIDER, 2, clock_in cycles per spi_clock_out half-period (legal ≥1).
COUNT_WIDTH, 16, width of byte-count inputs and internal counters.

Ports:
clock_in  input  1  system clock
reset_n_in  input  1  asynchronous active-low reset
start_in  input  1  single-cycle request; sampled only when busy_out=0
opcode_in  input  8  opcode byte; captured at accepted start
wr_byte_count_in  input  COUNT_WIDTH  operand bytes to write; captured at start
rd_byte_count_in  input  COUNT_WIDTH  bytes to read; captured at start
wr_data_in  input  8  next operand byte
wr_data_valid_in  input  1  wr_data_in valid
wr_data_ready_out  output  1  controller accepts wr_data_in this cycle
rd_data_out  output  8  last received byte
rd_data_valid_out  output  1  single-cycle pulse, rd_data_out new
busy_out  output  1  transaction or CS-high gap in progress
done_out  output  1  single-cycle pulse when CS deasserts
spi_select_out  output  1  chip select, active low
spi_clock_out  output  1  SPI clock, idle low
spi_data_out  output  1  controller-to-peripheral data
spi_data_in  input  1  peripheral-to-controller data

Behaviour:
- Reset (async, immediate, even mid-transfer):
  - spi_select_out=1, spi_clock_out=0, spi_data_out=0.
  - busy_out=0, done_out=0, wr_data_ready_out=0, rd_data_valid_out=0, rd_data_out=0.
  - State IDLE.
- States: IDLE, SETUP, SHIFT, LOAD, HOLD, GAP.
- IDLE:
  - start_in=1 at edge k captures opcode and counts.
  - At k+1: spi_select_out=0, busy_out=1, shift register=opcode, state SETUP.
  - start_in while busy_out=1 is ignored; no queuing.
- SETUP: CLOCK_DIVIDER cycles with SCLK low and spi_data_out=MSB of opcode, then SHIFT.
- SHIFT, per bit:
  - CLOCK_DIVIDER cycles SCLK low with spi_data_out = current bit, then CLOCK_DIVIDER cycles SCLK high.
  - spi_data_in is sampled on the clock_in edge that drives SCLK 0→1.
  - spi_data_out changes only on the edge that drives SCLK 1→0 (or on entering a byte).
  - 8 bits per byte; byte order is opcode, then wr_byte_count_in write bytes, then rd_byte_count_in read bytes.
- LOAD, entered before each write byte:
  - wr_data_ready_out=1 with SCLK low and CS low.
  - Transfer occurs on the first cycle with wr_data_valid_in=1, after which the byte starts shifting.
  - Minimum 1 cycle; the stall is unbounded while valid stays low.
- Read bytes:
  - spi_data_out=0 for the whole byte.
  - After the 8th SCLK 1→0 edge, rd_data_out is updated and rd_data_valid_out pulses 1 cycle.
  - There is no backpressure on read data.
- HOLD:
  - After the final byte's last high phase, SCLK=0 for CLOCK_DIVIDER cycles.
  - Then spi_select_out=1 and done_out pulses in that same cycle.
- GAP:
  - CLOCK_DIVIDER cycles with CS high and busy_out=1, then IDLE.
  - busy_out falls to 0 on entering IDLE.
- Counts of zero:
  - wr=0 and rd=0 gives an opcode-only transaction.
  - wr=0 skips LOAD entirely.
- CS-low length:
  - Without stalls: CLOCK_DIVIDER·(2 + 16·(1+wr+rd)) cycles, plus one LOAD cycle per write byte.
- No glitches on spi_clock_out or spi_select_out: both are registered outputs.

Test Plan:
- Opcode only: CLOCK_DIVIDER=2, opcode 0xDB, wr=0, rd=0 → CS low exactly 36 cycles, MOSI 11011011 on 8 rising edges, done_out 1 pulse at CS rise, busy_out low 2 cycles later.
- Chip-ID readback: opcode 0xDB, rd=1, peripheral model returns 0x81 → rd_data_out=0x81 with a single rd_data_valid_out pulse, 16 rising SCLK edges total.
- Write with stall: opcode 0x12, wr=2, data 0xA5 then 0x3C, valid withheld 10 cycles before second byte → SCLK held low and CS low during stall, MOSI bytes 0x12,0xA5,0x3C, exactly 2 ready&valid handshakes.
- Ignored start: start_in pulsed mid-transfer and during GAP → no effect, single done_out, opcode captured at first start unchanged.
- Reset mid-operation: reset_n_in low after 3rd bit of a write byte → CS=1, SCLK=0, all pulses 0 immediately. After release, a fresh opcode-only transaction completes normally.
- Divider edge: CLOCK_DIVIDER=1, wr=1, rd=1 → SCLK period 2 cycles, CS low 1+2·24/... per formula (2+48)=50 cycles plus 1 LOAD cycle, read byte matches model.
